// File: rtl/line_queue_scheduler.sv
// Work-queue scheduler for the nonogram solver: seeds every row/column, issues lines one at a time
// and re-queues the crossing lines of newly determined cells until fixpoint or contradiction.
module line_queue_scheduler #(
  parameter int MAX_ROWS = 16,
  parameter int MAX_COLS = 16,
  parameter int LINES    = MAX_ROWS + MAX_COLS,
  parameter int ID_W     = $clog2(LINES),
  parameter int MAXL     = (MAX_ROWS > MAX_COLS) ? MAX_ROWS : MAX_COLS,
  parameter int RW       = $clog2(MAX_ROWS + 1),
  parameter int CW       = $clog2(MAX_COLS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [RW-1:0]   num_rows,
  input  logic [CW-1:0]   num_cols,
  output logic            line_valid,
  output logic [ID_W-1:0] line_id,
  input  logic            line_ready,
  input  logic            res_valid,
  input  logic [ID_W-1:0] res_id,
  input  logic [MAXL-1:0] res_changed,
  input  logic            res_contradict,
  output logic            res_ready,
  output logic            busy,
  output logic            solved,
  output logic            contradiction,
  output logic [ID_W:0]   pending_count
);

  localparam int KW = (MAXL > 1) ? $clog2(MAXL) : 1;
  localparam int IW = ID_W + 2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEED     = 3'd1,
    S_RUN      = 3'd2,
    S_EXPAND   = 3'd3,
    S_DONE_OK  = 3'd4,
    S_DONE_ERR = 3'd5
  } state_t;

  state_t          state_r, state_next_s;
  logic [ID_W-1:0] queue_r [LINES];
  logic [ID_W-1:0] head_r, tail_r;
  logic [ID_W:0]   count_r;
  logic [LINES-1:0] pending_r;
  logic [IW-1:0]   inflight_r;
  logic [ID_W:0]   seed_idx_r;
  logic [RW-1:0]   nrows_r;
  logic [CW-1:0]   ncols_r;
  logic [MAXL-1:0] mask_r;
  logic            mask_row_r;
  logic            solved_r, contra_r;

  logic            active_s, seed_or_run_s, res_ready_s, line_valid_s;
  logic            empty_s, pop_s, accept_s, contra_s;
  logic [ID_W-1:0] head_id_s;
  logic [ID_W:0]   seed_total_s;
  logic            seed_none_s, seed_last_s;
  logic [ID_W-1:0] seed_id_s;
  logic [KW-1:0]   exp_k_s;
  logic [MAXL-1:0] exp_bit_s, mask_rest_s, lim_mask_s, changed_s;
  logic [ID_W-1:0] exp_id_s;
  logic            res_row_s;
  logic            push_req_s, push_s, pend_eff_s;
  logic [ID_W-1:0] push_id_s;

  function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] p);
    if (p == ID_W'(LINES - 1)) begin
      return {ID_W{1'b0}};
    end else begin
      return p + ID_W'(1);
    end
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; start restarts from any state
  always_comb begin
    state_next_s = state_r;
    if (start) begin
      state_next_s = S_SEED;
    end else begin
      case (state_r)
        S_IDLE:     state_next_s = S_IDLE;
        S_SEED: begin
          if (contra_s)                        state_next_s = S_DONE_ERR;
          else if (seed_none_s || seed_last_s) state_next_s = S_RUN;
          else                                 state_next_s = S_SEED;
        end
        S_RUN: begin
          if (contra_s)                                    state_next_s = S_DONE_ERR;
          else if (mask_r != {MAXL{1'b0}})                 state_next_s = S_EXPAND;
          else if (accept_s && changed_s != {MAXL{1'b0}})  state_next_s = S_EXPAND;
          else if (empty_s && inflight_r == {IW{1'b0}})    state_next_s = S_DONE_OK;
          else                                             state_next_s = S_RUN;
        end
        S_EXPAND: begin
          if (mask_rest_s == {MAXL{1'b0}}) state_next_s = S_RUN;
          else                             state_next_s = S_EXPAND;
        end
        S_DONE_OK:  state_next_s = S_DONE_OK;
        S_DONE_ERR: state_next_s = S_DONE_ERR;
        default:    state_next_s = S_IDLE;
      endcase
    end
  end

  // State-decoded handshake and status outputs
  always_comb begin
    active_s      = 1'b0;
    seed_or_run_s = 1'b0;
    case (state_r)
      S_SEED:   begin active_s = 1'b1; seed_or_run_s = 1'b1; end
      S_RUN:    begin active_s = 1'b1; seed_or_run_s = 1'b1; end
      S_EXPAND: begin active_s = 1'b1; seed_or_run_s = 1'b0; end
      default:  begin active_s = 1'b0; seed_or_run_s = 1'b0; end
    endcase
    // a held expand mask blocks new results so it is never overwritten
    res_ready_s  = seed_or_run_s && (mask_r == {MAXL{1'b0}});
    line_valid_s = active_s && !empty_s;
  end

  // Queue, seeding and expansion datapath decode
  always_comb begin
    head_id_s = queue_r[head_r];
    empty_s   = (count_r == {(ID_W+1){1'b0}});
    pop_s     = line_valid_s && line_ready;
    accept_s  = res_valid && res_ready_s && (inflight_r != {IW{1'b0}});
    contra_s  = accept_s && res_contradict;

    seed_total_s = (ID_W+1)'(nrows_r) + (ID_W+1)'(ncols_r);
    seed_none_s  = (nrows_r == {RW{1'b0}}) || (ncols_r == {CW{1'b0}});
    seed_last_s  = (seed_idx_r == seed_total_s - (ID_W+1)'(1));
    if (seed_idx_r < (ID_W+1)'(nrows_r)) begin
      seed_id_s = seed_idx_r[ID_W-1:0];
    end else begin
      seed_id_s = ID_W'(MAX_ROWS) + ID_W'(seed_idx_r - (ID_W+1)'(nrows_r));
    end

    exp_k_s = {KW{1'b0}};
    for (int k = MAXL - 1; k >= 0; k--) begin
      if (mask_r[k]) exp_k_s = KW'(k);
      else           exp_k_s = exp_k_s;
    end
    exp_bit_s   = MAXL'(1) << exp_k_s;
    mask_rest_s = mask_r & ~exp_bit_s;
    if (mask_row_r) exp_id_s = ID_W'(MAX_ROWS) + ID_W'(exp_k_s);
    else            exp_id_s = ID_W'(exp_k_s);

    // row results cross columns, so only bits inside the puzzle width count (and vice versa)
    res_row_s = ({1'b0, res_id} < (ID_W+1)'(MAX_ROWS));
    for (int k = 0; k < MAXL; k++) begin
      if (res_row_s) lim_mask_s[k] = (k < int'(ncols_r));
      else           lim_mask_s[k] = (k < int'(nrows_r));
    end
    changed_s = res_changed & lim_mask_s;

    if (state_r == S_SEED && !seed_none_s) begin
      push_req_s = 1'b1;
      push_id_s  = seed_id_s;
    end else if (state_r == S_EXPAND && mask_r != {MAXL{1'b0}}) begin
      push_req_s = 1'b1;
      push_id_s  = exp_id_s;
    end else begin
      push_req_s = 1'b0;
      push_id_s  = {ID_W{1'b0}};
    end
    // a line leaving the head this cycle is no longer pending and may be re-queued
    pend_eff_s = pending_r[push_id_s] && !(pop_s && head_id_s == push_id_s);
    push_s     = push_req_s && !pend_eff_s;
  end

  // Queue storage, pending bitmap, in-flight count and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LINES; i++) queue_r[i] <= {ID_W{1'b0}};
      head_r     <= {ID_W{1'b0}};
      tail_r     <= {ID_W{1'b0}};
      count_r    <= {(ID_W+1){1'b0}};
      pending_r  <= {LINES{1'b0}};
      inflight_r <= {IW{1'b0}};
      seed_idx_r <= {(ID_W+1){1'b0}};
      nrows_r    <= {RW{1'b0}};
      ncols_r    <= {CW{1'b0}};
      mask_r     <= {MAXL{1'b0}};
      mask_row_r <= 1'b0;
      solved_r   <= 1'b0;
      contra_r   <= 1'b0;
    end else if (start) begin
      head_r     <= {ID_W{1'b0}};
      tail_r     <= {ID_W{1'b0}};
      count_r    <= {(ID_W+1){1'b0}};
      pending_r  <= {LINES{1'b0}};
      inflight_r <= {IW{1'b0}};
      seed_idx_r <= {(ID_W+1){1'b0}};
      nrows_r    <= num_rows;
      ncols_r    <= num_cols;
      mask_r     <= {MAXL{1'b0}};
      mask_row_r <= 1'b0;
      solved_r   <= 1'b0;
      contra_r   <= 1'b0;
    end else if (contra_s) begin
      head_r     <= {ID_W{1'b0}};
      tail_r     <= {ID_W{1'b0}};
      count_r    <= {(ID_W+1){1'b0}};
      pending_r  <= {LINES{1'b0}};
      inflight_r <= {IW{1'b0}};
      mask_r     <= {MAXL{1'b0}};
      solved_r   <= 1'b0;
      contra_r   <= 1'b1;
    end else begin
      if (pop_s) begin
        head_r               <= ptr_inc(head_r);
        pending_r[head_id_s] <= 1'b0;
      end
      if (push_s) begin
        queue_r[tail_r]      <= push_id_s;
        tail_r               <= ptr_inc(tail_r);
        pending_r[push_id_s] <= 1'b1;
      end
      count_r <= count_r + {{ID_W{1'b0}}, push_s} - {{ID_W{1'b0}}, pop_s};

      if (pop_s && !accept_s && inflight_r != {IW{1'b1}}) begin
        inflight_r <= inflight_r + IW'(1);
      end else if (accept_s && !pop_s) begin
        inflight_r <= inflight_r - IW'(1);
      end

      if (state_r == S_SEED && push_req_s) begin
        seed_idx_r <= seed_idx_r + (ID_W+1)'(1);
      end

      if (accept_s && changed_s != {MAXL{1'b0}}) begin
        mask_r     <= changed_s;
        mask_row_r <= res_row_s;
      end else if (state_r == S_EXPAND) begin
        mask_r     <= mask_rest_s;
      end

      solved_r <= (state_next_s == S_DONE_OK);
    end
  end

  assign line_valid    = line_valid_s;
  assign line_id       = head_id_s;
  assign res_ready     = res_ready_s;
  assign busy          = active_s;
  assign solved        = solved_r;
  assign contradiction = contra_r;
  assign pending_count = count_r;

endmodule

// File: tb/tb_line_queue_scheduler.sv
// Directed bench for line_queue_scheduler: seeding table plus hand sequences for expand,
// solve, contradiction and asynchronous reset.
module tb_line_queue_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  num_rows, num_cols;
  logic        line_valid;
  logic [4:0]  line_id;
  logic        line_ready;
  logic        res_valid;
  logic [4:0]  res_id;
  logic [15:0] res_changed;
  logic        res_contradict;
  logic        res_ready, busy, solved, contradiction;
  logic [5:0]  pending_count;

  line_queue_scheduler #(.MAX_ROWS(16), .MAX_COLS(16)) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .num_cols(num_cols),
    .line_valid(line_valid), .line_id(line_id), .line_ready(line_ready),
    .res_valid(res_valid), .res_id(res_id), .res_changed(res_changed),
    .res_contradict(res_contradict), .res_ready(res_ready), .busy(busy),
    .solved(solved), .contradiction(contradiction), .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [4:0] popped [$];

  typedef struct {
    int r;
    int c;
    int exp_cnt;
    int exp_first;
    int exp_last;
  } vec_t;
  vec_t vt [5];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    if (line_valid && line_ready) popped.push_back(line_id);
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int r, input int c);
    num_rows = 5'(r);
    num_cols = 5'(c);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic send_result(input int id, input logic [15:0] chg, input logic contra);
    for (int i = 0; i < 20 && !res_ready; i++) tick();
    check("res_ready_wait", int'(res_ready), 1);
    res_valid      = 1'b1;
    res_id         = 5'(id);
    res_changed    = chg;
    res_contradict = contra;
    tick();
    res_valid      = 1'b0;
    res_changed    = 16'h0000;
    res_contradict = 1'b0;
  endtask

  initial begin
    int peak;
    int exp_id;
    int ids [5];
    rst = 1'b0; start = 1'b0; num_rows = 5'd0; num_cols = 5'd0;
    line_ready = 1'b0; res_valid = 1'b0; res_id = 5'd0;
    res_changed = 16'h0000; res_contradict = 1'b0;

    vt[0] = '{r: 2,  c: 2,  exp_cnt: 4,  exp_first: 0, exp_last: 17};
    vt[1] = '{r: 3,  c: 3,  exp_cnt: 6,  exp_first: 0, exp_last: 18};
    vt[2] = '{r: 1,  c: 16, exp_cnt: 17, exp_first: 0, exp_last: 31};
    vt[3] = '{r: 16, c: 16, exp_cnt: 32, exp_first: 0, exp_last: 31};
    vt[4] = '{r: 4,  c: 1,  exp_cnt: 5,  exp_first: 0, exp_last: 16};

    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_line_valid", int'(line_valid), 0);
    check("rst_res_ready", int'(res_ready), 0);
    check("rst_solved", int'(solved), 0);
    check("rst_count", int'(pending_count), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // seeding table: hold the simplifier off, then drain, then return everything unchanged
    for (int v = 0; v < 5; v++) begin
      line_ready = 1'b0;
      do_start(vt[v].r, vt[v].c);
      repeat (vt[v].r + vt[v].c + 1) tick();
      check("seed_count", int'(pending_count), vt[v].exp_cnt);
      check("seed_head", int'(line_id), vt[v].exp_first);
      check("seed_busy", int'(busy), 1);
      check("seed_solved", int'(solved), 0);
      popped.delete();
      line_ready = 1'b1;
      repeat (vt[v].exp_cnt + 2) tick();
      line_ready = 1'b0;
      check("drain_size", popped.size(), vt[v].exp_cnt);
      for (int i = 0; i < vt[v].exp_cnt && i < popped.size(); i++) begin
        exp_id = (i < vt[v].r) ? i : 16 + (i - vt[v].r);
        check("drain_order", int'(popped[i]), exp_id);
      end
      if (popped.size() > 0) check("drain_last", int'(popped[popped.size()-1]), vt[v].exp_last);
      else                   check("drain_last_missing", 0, 1);
      check("drain_count", int'(pending_count), 0);
      for (int i = 0; i < vt[v].exp_cnt; i++) send_result(0, 16'h0000, 1'b0);
      check("pre_solved", int'(solved), 0);
      tick();
      check("solved", int'(solved), 1);
      check("solved_busy", int'(busy), 0);
      check("solved_line_valid", int'(line_valid), 0);
      check("done_res_ready", int'(res_ready), 0);
    end

    // 2x2 with simplifier always ready: pops interleave with seeding
    line_ready = 1'b1;
    popped.delete();
    do_start(2, 2);
    peak = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (int'(pending_count) > peak) peak = int'(pending_count);
    end
    line_ready = 1'b0;
    check("t1_peak", peak, 1);
    check("t1_size", popped.size(), 4);
    ids = '{0, 1, 16, 17, 0};
    for (int i = 0; i < 4 && i < popped.size(); i++) check("t1_order", int'(popped[i]), ids[i]);

    // empty puzzle solves straight away
    do_start(0, 5);
    check("zero_busy", int'(busy), 1);
    tick();
    tick();
    check("zero_solved", int'(solved), 1);
    check("zero_count", int'(pending_count), 0);
    check("zero_busy_done", int'(busy), 0);

    // expansion with pending filtering and masking (2 rows, 4 cols)
    do_start(2, 4);
    repeat (7) tick();
    check("t3_seeded", int'(pending_count), 6);
    popped.delete();
    line_ready = 1'b1;
    repeat (6) tick();
    line_ready = 1'b0;
    check("t3_all_issued", popped.size(), 6);
    send_result(1, 16'h0001, 1'b0);
    check("t3a_expand", int'(res_ready), 0);
    tick();
    check("t3a_count", int'(pending_count), 1);
    check("t3a_head", int'(line_id), 16);
    check("t3a_back_run", int'(res_ready), 1);
    send_result(0, 16'hF0F5, 1'b0);
    check("t3b_expand1", int'(res_ready), 0);
    tick();
    check("t3b_no_push", int'(pending_count), 1);
    check("t3b_expand2", int'(res_ready), 0);
    tick();
    check("t3b_push18", int'(pending_count), 2);
    check("t3b_back_run", int'(res_ready), 1);
    check("t3b_head", int'(line_id), 16);
    popped.delete();
    line_ready = 1'b1;
    repeat (2) tick();
    line_ready = 1'b0;
    check("t3_pop_size", popped.size(), 2);
    if (popped.size() == 2) begin
      check("t3_pop0", int'(popped[0]), 16);
      check("t3_pop1", int'(popped[1]), 18);
    end else begin
      check("t3_pop_missing", popped.size(), 2);
    end
    send_result(17, 16'h00FC, 1'b0);
    check("t3c_masked_no_expand", int'(res_ready), 1);
    check("t3c_count", int'(pending_count), 0);
    for (int i = 0; i < 5; i++) send_result(16, 16'h0000, 1'b0);
    check("t4_pre_solved", int'(solved), 0);
    tick();
    check("t4_solved", int'(solved), 1);
    check("t4_busy", int'(busy), 0);

    // contradiction with five lines still queued
    do_start(3, 3);
    repeat (7) tick();
    line_ready = 1'b1;
    tick();
    line_ready = 1'b0;
    check("t5_queued", int'(pending_count), 5);
    send_result(0, 16'h0003, 1'b1);
    check("t5_contra", int'(contradiction), 1);
    check("t5_count", int'(pending_count), 0);
    check("t5_line_valid", int'(line_valid), 0);
    check("t5_busy", int'(busy), 0);
    check("t5_solved", int'(solved), 0);
    res_valid = 1'b1;
    tick();
    check("t5_late_res_ready", int'(res_ready), 0);
    res_valid = 1'b0;
    check("t5_count_hold", int'(pending_count), 0);

    // asynchronous reset in the middle of an expansion, then a clean restart
    do_start(2, 4);
    repeat (7) tick();
    line_ready = 1'b1;
    tick();
    line_ready = 1'b0;
    send_result(0, 16'h000F, 1'b0);
    tick();
    check("t6_in_expand", int'(busy) * 2 + int'(res_ready), 2);
    #2;
    rst = 1'b0;
    #1;
    check("t6_busy", int'(busy), 0);
    check("t6_line_valid", int'(line_valid), 0);
    check("t6_line_id", int'(line_id), 0);
    check("t6_res_ready", int'(res_ready), 0);
    check("t6_solved", int'(solved), 0);
    check("t6_contra", int'(contradiction), 0);
    check("t6_count", int'(pending_count), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    line_ready = 1'b1;
    popped.delete();
    do_start(2, 2);
    repeat (7) tick();
    line_ready = 1'b0;
    check("t6_reseed_size", popped.size(), 4);
    for (int i = 0; i < 4 && i < popped.size(); i++) check("t6_reseed_order", int'(popped[i]), ids[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
